// File: rtl/ethernet_fmc_core_seq_pkg.sv
// Shared opcode, state encoding and default timing constants for the core sequencer.
package ethernet_fmc_core_seq_pkg;

  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 3;

  // Host command opcodes
  typedef enum logic [OP_W-1:0] {
    OP_NOP     = 2'd0,
    OP_START   = 2'd1,
    OP_STOP    = 2'd2,
    OP_RESTART = 2'd3
  } op_e;

  // Sequencer states; encodings are visible to software through state_o
  typedef enum logic [STATE_W-1:0] {
    ST_OFF        = 3'd0,
    ST_START_WAIT = 3'd1,
    ST_RUNNING    = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_OFF_HOLD   = 3'd4
  } state_e;

  localparam int unsigned EN_DELAY_DEF   = 16;
  localparam int unsigned STOP_DELAY_DEF = 8;
  localparam int unsigned DRAIN_MAX_DEF  = 1024;
  localparam int unsigned WDOG_W_DEF     = 16;

  // Largest of three delays, used to size the shared sequencing counter
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ethernet_fmc_core_wdog.sv
// Watchdog: counts while the core runs, cleared by kicks or RUNNING entry, pulses on timeout.
module ethernet_fmc_core_wdog
  import ethernet_fmc_core_seq_pkg::*;
#(
  parameter int unsigned WDOG_W = WDOG_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              kick_i,
  input  logic              suppress_i,
  input  logic [WDOG_W-1:0] limit_i,
  output logic              fired_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              fired_q, fired_d;
  logic              timeout_c;

  // Timeout compare; a same-cycle kick wins, an accepted STOP/RESTART masks the pulse
  always_comb begin
    timeout_c = en_i && (limit_i != '0) && (cnt_q == (limit_i - WDOG_W'(1))) && !kick_i;
    fired_d   = timeout_c && !suppress_i;
    cnt_d     = cnt_q;
    if (clr_i || kick_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // Counter and registered fire pulse
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  assign fired_o = fired_q;

endmodule

// File: rtl/ethernet_fmc_core_seq.sv
// Command-driven power sequencer: enables the core, drains it before gating, enforces hold-off.
module ethernet_fmc_core_seq
  import ethernet_fmc_core_seq_pkg::*;
#(
  parameter int unsigned EN_DELAY   = EN_DELAY_DEF,
  parameter int unsigned STOP_DELAY = STOP_DELAY_DEF,
  parameter int unsigned DRAIN_MAX  = DRAIN_MAX_DEF,
  parameter int unsigned WDOG_W     = WDOG_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              cmd_valid_i,
  input  logic [OP_W-1:0]   cmd_op_i,
  output logic              cmd_ready_o,
  output logic              core_en_o,
  input  logic              core_idle_i,
  input  logic              wdog_kick_i,
  input  logic [WDOG_W-1:0] wdog_limit_i,
  output logic [STATE_W-1:0] state_o,
  output logic              wdog_fired_o,
  output logic              drain_err_o
);

  localparam int unsigned CNT_W = $clog2(max3(EN_DELAY, STOP_DELAY, DRAIN_MAX)) + 1;
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_DELAY - 1);
  localparam logic [CNT_W-1:0] STOP_LAST  = CNT_W'(STOP_DELAY - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             restart_q, restart_d;
  logic             drain_err_q, drain_err_d;
  logic             core_en_q, core_en_d;
  logic             cmd_ready_q, cmd_ready_d;

  op_e              op_c;
  logic             cmd_acc_c;
  logic             halt_acc_c;
  logic             wdog_fire;
  logic             wdog_en_c;
  logic             wdog_clr_c;

  assign op_c       = op_e'(cmd_op_i);
  assign cmd_acc_c  = cmd_valid_i && cmd_ready_q;
  assign halt_acc_c = cmd_acc_c && (state_q == ST_RUNNING) &&
                      ((op_c == OP_STOP) || (op_c == OP_RESTART));
  assign wdog_en_c  = (state_q == ST_RUNNING);
  assign wdog_clr_c = (state_d == ST_RUNNING) && (state_q != ST_RUNNING);

  // Next-state, counter, restart flag and decoded outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    restart_d   = restart_q;
    drain_err_d = drain_err_q;
    if (cmd_acc_c) begin
      drain_err_d = 1'b0;
    end
    unique case (state_q)
      ST_OFF: begin
        if (cmd_acc_c && ((op_c == OP_START) || (op_c == OP_RESTART))) begin
          state_d = ST_START_WAIT;
          cnt_d   = '0;
        end
      end
      ST_START_WAIT: begin
        if (cnt_q == EN_LAST) begin
          state_d = ST_RUNNING;
          cnt_d   = '0;
        end
      end
      ST_RUNNING: begin
        if (halt_acc_c) begin
          state_d   = ST_DRAIN;
          cnt_d     = '0;
          restart_d = (op_c == OP_RESTART);
        end else if (wdog_fire) begin
          state_d   = ST_DRAIN;
          cnt_d     = '0;
          restart_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (core_idle_i) begin
          state_d = ST_OFF_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d     = ST_OFF_HOLD;
          cnt_d       = '0;
          drain_err_d = 1'b1;
        end
      end
      ST_OFF_HOLD: begin
        if (cnt_q == STOP_LAST) begin
          state_d   = restart_q ? ST_START_WAIT : ST_OFF;
          cnt_d     = '0;
          restart_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_OFF;
        cnt_d     = '0;
        restart_d = 1'b0;
      end
    endcase
    core_en_d   = (state_d == ST_START_WAIT) || (state_d == ST_RUNNING) || (state_d == ST_DRAIN);
    cmd_ready_d = (state_d == ST_OFF) || (state_d == ST_RUNNING);
  end

  // Sequencer registers; async reset drops the enable without draining
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      restart_q   <= 1'b0;
      drain_err_q <= 1'b0;
      core_en_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      restart_q   <= restart_d;
      drain_err_q <= drain_err_d;
      core_en_q   <= core_en_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  ethernet_fmc_core_wdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (wdog_en_c),
    .clr_i      (wdog_clr_c),
    .kick_i     (wdog_kick_i),
    .suppress_i (halt_acc_c),
    .limit_i    (wdog_limit_i),
    .fired_o    (wdog_fire)
  );

  assign state_o      = state_q;
  assign core_en_o    = core_en_q;
  assign cmd_ready_o  = cmd_ready_q;
  assign drain_err_o  = drain_err_q;
  assign wdog_fired_o = wdog_fire;

endmodule
